execute_cycle: RTL



---
 rtl/execute_cycle.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_cycle.sv
// execute_cycle: EX stage of the scalar/vector pipeline. Forwarding, a 4-lane
// 32-bit ALU, branch resolve and the EX/MEM register. Vector MUL is built only
// when EXEC_VEC_MUL_EN is defined: one lane per cycle through a single
// multiplier, with StallE holding upstream. Otherwise ALU op 110 yields 0.
// Ports:
//   clk, rst                 clock, sync active-high reset
//   *E control bits          RegWrite/ALUSrc/MemWrite/ResultSrc/Branch/vectorial
//   ALUControlE[2:0]         ALU op
//   RD1_E, RD2_E[127:0]      register operands
//   Imm_Ext_E, PCE, PCPlus4E immediate, PC, PC+4
//   RD_E[5:0]                destination register
//   ForwardAE/BE[1:0]        forwarding selects
//   ResultW[127:0]           writeback result for forwarding
//   PCSrcE, PCTargetE        branch taken / target (combinational)
//   StallE                   multiply in progress, upstream holds
//   *M outputs               registered EX/MEM bundle
module execute_cycle (
  input  logic         clk,
  input  logic         rst,
  input  logic         RegWriteE,
  input  logic         ALUSrcE,
  input  logic         MemWriteE,
  input  logic         ResultSrcE,
  input  logic         BranchE,
  input  logic         vectorialE,
  input  logic [2:0]   ALUControlE,
  input  logic [127:0] RD1_E,
  input  logic [127:0] RD2_E,
  input  logic [31:0]  Imm_Ext_E,
  input  logic [31:0]  PCE,
  input  logic [31:0]  PCPlus4E,
  input  logic [5:0]   RD_E,
  input  logic [1:0]   ForwardAE,
  input  logic [1:0]   ForwardBE,
  input  logic [127:0] ResultW,
  output logic         PCSrcE,
  output logic [31:0]  PCTargetE,
  output logic         StallE,
  output logic         RegWriteM,
  output logic         MemWriteM,
  output logic         ResultSrcM,
  output logic         vectorialM,
  output logic [127:0] ALUResultM,
  output logic [127:0] WriteDataM,
  output logic [5:0]   RD_M,
  output logic [31:0]  PCPlus4M
);

  localparam int LANES = 4;

  typedef struct packed {
    logic         reg_write;
    logic         mem_write;
    logic         result_src;
    logic         vectorial;
    logic [5:0]   rd;
    logic [31:0]  pc_plus4;
    logic [127:0] wd;
  } ctl_t;

  typedef struct packed {
    ctl_t         c;
    logic [127:0] alu;
  } ex_mem_t;

  ex_mem_t      m_q;
  ex_mem_t      m_d;
  ex_mem_t      e_bun;
  logic [127:0] src_a;
  logic [127:0] fwd_b;
  logic [127:0] src_b;
  logic [127:0] imm_v;
  logic [127:0] alu_res;

  function automatic logic [127:0] fwd_sel(
    input logic [1:0]   s,
    input logic [127:0] reg_v,
    input logic [127:0] wb_v,
    input logic [127:0] mem_v
  );
    logic [127:0] r;
    unique case (s)
      2'b01:   r = wb_v;
      2'b10:   r = mem_v;
      default: r = reg_v;
    endcase
    return r;
  endfunction

  // MUL (110) is handled outside this function by the shared multiplier.
  function automatic logic [31:0] alu_lane(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    unique case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = {31'd0, $signed(a) < $signed(b)};
      3'b111:  r = a << b[4:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    imm_v = vectorialE ? {LANES{Imm_Ext_E}} : {96'd0, Imm_Ext_E};
    src_a = fwd_sel(ForwardAE, RD1_E, ResultW, ALUResultM);
    fwd_b = fwd_sel(ForwardBE, RD2_E, ResultW, ALUResultM);
    src_b = ALUSrcE ? imm_v : fwd_b;
  end

  assign PCSrcE    = BranchE & (src_a[31:0] == src_b[31:0]);
  assign PCTargetE = PCE + Imm_Ext_E;

`ifdef EXEC_VEC_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  state_t       state;
  logic [1:0]   k;
  logic [127:0] lat_a;
  logic [127:0] lat_b;
  ctl_t         lat_c;
  logic [95:0]  acc;
  logic [31:0]  mul_a;
  logic [31:0]  mul_b;
  logic [31:0]  mul_p;
  logic         accept;
  logic         last;

  // One multiplier: lane 0 of live operands in IDLE, latched lane k in MUL.
  assign mul_a = (state == MUL) ? lat_a[{k, 5'd0} +: 32] : src_a[31:0];
  assign mul_b = (state == MUL) ? lat_b[{k, 5'd0} +: 32] : src_b[31:0];
  assign mul_p = mul_a * mul_b;

  assign accept = (state == IDLE) & vectorialE & (ALUControlE == 3'b110);
  assign last   = (state == MUL) & (k == 2'd3);
  assign StallE = ~rst & (accept | ((state == MUL) & (k != 2'd3)));
`else
  assign StallE = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    for (int i = 0; i < LANES; i++) begin
      if (vectorialE || i == 0) begin
        alu_res[i*32 +: 32] = alu_lane(ALUControlE,
                                       src_a[i*32 +: 32],
                                       src_b[i*32 +: 32]);
      end
    end
`ifdef EXEC_VEC_MUL_EN
    if (ALUControlE == 3'b110 && !vectorialE) begin
      alu_res[31:0] = mul_p;
    end
`endif
  end

  always_comb begin
    e_bun.c.reg_write  = RegWriteE;
    e_bun.c.mem_write  = MemWriteE;
    e_bun.c.result_src = ResultSrcE;
    e_bun.c.vectorial  = vectorialE;
    e_bun.c.rd         = RD_E;
    e_bun.c.pc_plus4   = PCPlus4E;
    e_bun.c.wd         = fwd_b;
    e_bun.alu          = alu_res;
  end

`ifdef EXEC_VEC_MUL_EN
  // Anything other than a normal IDLE issue or the final MUL lane is a bubble.
  always_comb begin
    m_d = '0;
    unique case (1'b1)
      (state == IDLE) && !accept: m_d = e_bun;
      last: begin
        m_d.c   = lat_c;
        m_d.alu = {mul_p, acc};
      end
      default: m_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= 2'd0;
      m_q   <= '0;
      lat_a <= '0;
      lat_b <= '0;
      lat_c <= '0;
      acc   <= '0;
    end else begin
      m_q <= m_d;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= MUL;
            k     <= 2'd0;
            lat_a <= src_a;
            lat_b <= src_b;
            lat_c <= e_bun.c;
          end
        end
        MUL: begin
          if (k == 2'd3) begin
            state <= IDLE;
            k     <= 2'd0;
          end else begin
            acc[{k, 5'd0} +: 32] <= mul_p;
            k <= k + 2'd1;
          end
        end
      endcase
    end
  end
`else
  assign m_d = e_bun;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
    end else begin
      m_q <= m_d;
    end
  end
`endif

  assign RegWriteM  = m_q.c.reg_write;
  assign MemWriteM  = m_q.c.mem_write;
  assign ResultSrcM = m_q.c.result_src;
  assign vectorialM = m_q.c.vectorial;
  assign RD_M       = m_q.c.rd;
  assign PCPlus4M   = m_q.c.pc_plus4;
  assign WriteDataM = m_q.c.wd;
  assign ALUResultM = m_q.alu;

endmodule
